// File: rtl/useq_sequencer.sv
// Microprogram sequencer: control register, incrementer, conditional branch/wait and a bounded return stack.
// Optional watchdog on CWAIT enabled by defining USEQ_WDT_EN.
module useq_sequencer #(
   parameter int AW          = 8,
   parameter int CW          = 39,
   parameter int NCOND       = 4,
   parameter int STACK_DEPTH = 4,
   parameter int WDT_LIMIT   = 255,
   parameter logic [AW-1:0] TRAP_ADDR = {AW{1'b1}},
   localparam int SW = (NCOND > 1) ? $clog2(NCOND) : 1,
   localparam int UW = CW + AW + SW + 4
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic [AW-1:0] entry_addr,
   input  logic [NCOND-1:0] cond_in,
   input  logic [UW-1:0] urom_data,
   output logic [AW-1:0] uaddr,
   output logic [CW-1:0] ctrl_out,
   output logic          stk_ovf,
   output logic          stk_unf,
   output logic          wdt_trip
);

   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int AIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      M_JUMP     = 3'd0,
      M_INC      = 3'd1,
      M_DISPATCH = 3'd2,
      M_CJUMP    = 3'd3,
      M_CWAIT    = 3'd4,
      M_CALL     = 3'd5,
      M_RET      = 3'd6,
      M_RSVD     = 3'd7
   } mode_e;

   logic [UW-1:0]  creg;
   logic [AW-1:0]  inc;
   logic [AW-1:0]  stack [STACK_DEPTH];
   logic [SPW-1:0] sp;

   mode_e          mode;
   logic           inv;
   logic [SW-1:0]  sel;
   logic [AW-1:0]  cr;
   logic           c_raw;
   logic           c;
   logic           stk_full;
   logic           stk_empty;
   logic [AW-1:0]  stk_top;
   logic [AIW-1:0] push_idx;
   logic [AIW-1:0] top_idx;
   logic           push;
   logic           pop;
   logic           wait_cyc;
   logic           trap;
   logic [AW-1:0]  uaddr_sel;

   assign mode     = mode_e'(creg[2:0]);
   assign inv      = creg[3];
   assign sel      = creg[3+SW:4];
   assign cr       = creg[3+SW+AW:4+SW];
   assign ctrl_out = creg[UW-1:UW-CW];

   // Selectors beyond NCOND read as 0, so c collapses to inv.
   always_comb begin
      c_raw = 1'b0;
      for (int i = 0; i < NCOND; i++) begin
         if (sel == SW'(i)) c_raw = cond_in[i];
      end
      c = c_raw ^ inv;
   end

   assign stk_full  = (sp == SPW'(STACK_DEPTH));
   assign stk_empty = (sp == '0);
   assign push_idx  = sp[AIW-1:0];
   assign top_idx   = AIW'(sp - SPW'(1));
   assign stk_top   = stack[top_idx];

   always_comb begin
      uaddr_sel = inc;
      push      = 1'b0;
      pop       = 1'b0;
      wait_cyc  = 1'b0;
      case (mode)
         M_JUMP:     uaddr_sel = cr;
         M_INC:      uaddr_sel = inc;
         M_DISPATCH: uaddr_sel = entry_addr;
         M_CJUMP:    uaddr_sel = c ? cr : inc;
         M_CWAIT: begin
            // inc-1 is the address of the executing word: reload it until c rises.
            uaddr_sel = c ? inc : (inc - AW'(1));
            wait_cyc  = ~c;
         end
         M_CALL: begin
            uaddr_sel = cr;
            push      = 1'b1;
         end
         M_RET: begin
            uaddr_sel = stk_empty ? '0 : stk_top;
            pop       = 1'b1;
         end
         default:    uaddr_sel = inc;
      endcase
   end

`ifdef USEQ_WDT_EN
   localparam int WW = ($clog2(WDT_LIMIT + 1) > 8) ? $clog2(WDT_LIMIT + 1) : 8;

   logic [WW-1:0] wdt_cnt;
   logic          wdt_flag;

   assign trap     = wait_cyc && (wdt_cnt == WW'(WDT_LIMIT));
   assign uaddr    = trap ? TRAP_ADDR : uaddr_sel;
   assign wdt_trip = wdt_flag;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wdt_cnt  <= '0;
         wdt_flag <= 1'b0;
      end else if (trap) begin
         wdt_cnt  <= '0;
         wdt_flag <= 1'b1;
      end else if (wait_cyc) begin
         wdt_cnt  <= wdt_cnt + WW'(1);
      end else begin
         wdt_cnt  <= '0;
      end
   end
`else
   assign trap     = 1'b0;
   assign uaddr    = uaddr_sel;
   assign wdt_trip = 1'b0;
`endif

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         creg    <= '0;
         inc     <= '0;
         sp      <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
      end else begin
         creg <= urom_data;
         inc  <= uaddr + AW'(1);
         // A full push still jumps; only the return address is lost.
         if (push) begin
            if (stk_full) begin
               stk_ovf <= 1'b1;
            end else begin
               stack[push_idx] <= inc;
               sp              <= sp + SPW'(1);
            end
         end
         if (pop) begin
            if (stk_empty) stk_unf <= 1'b1;
            else           sp      <= sp - SPW'(1);
         end
      end
   end

   logic unused_trap;
   assign unused_trap = trap;

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed bench for useq_sequencer: a bench-side microstore, a per-cycle expected queue and a negedge monitor.
module tb_useq_sequencer;

   localparam int AW    = 8;
   localparam int CW    = 39;
   localparam int NCOND = 4;
   localparam int SW    = 2;
   localparam int UW    = CW + AW + SW + 4;
   localparam int EW    = AW + CW + 3;
`ifdef USEQ_WDT_EN
   localparam int TB_WDT_LIMIT = 4;
`else
   localparam int TB_WDT_LIMIT = 255;
`endif

   localparam logic [2:0] M_JUMP = 3'd0, M_INC = 3'd1, M_DISPATCH = 3'd2, M_CJUMP = 3'd3;
   localparam logic [2:0] M_CWAIT = 3'd4, M_CALL = 3'd5, M_RET = 3'd6;

   logic          CLK;
   logic          reset;
   logic [AW-1:0] entry_addr;
   logic [NCOND-1:0] cond_in;
   logic [UW-1:0] urom_data;
   logic [AW-1:0] uaddr;
   logic [CW-1:0] ctrl_out;
   logic          stk_ovf;
   logic          stk_unf;
   logic          wdt_trip;

   logic [UW-1:0] urom [256];
   logic [EW-1:0] exp_q [$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;

   useq_sequencer #(
      .AW(AW), .CW(CW), .NCOND(NCOND), .STACK_DEPTH(4),
      .WDT_LIMIT(TB_WDT_LIMIT), .TRAP_ADDR(8'hFF)
   ) dut (
      .CLK(CLK), .reset(reset), .entry_addr(entry_addr), .cond_in(cond_in),
      .urom_data(urom_data), .uaddr(uaddr), .ctrl_out(ctrl_out),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf), .wdt_trip(wdt_trip)
   );

   // Clock and external combinational microstore.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   assign urom_data = urom[uaddr];

   function automatic logic [CW-1:0] cw_of(input int a);
      logic [AW-1:0] a8;
      a8 = AW'(a);
      return {7'h55, a8, 24'hA5C3E1};
   endfunction

   function automatic logic [UW-1:0] mk(input logic [2:0] mode, input logic inv,
                                        input logic [SW-1:0] sel, input int cr, input int a);
      logic [AW-1:0] cr8;
      cr8 = AW'(cr);
      return {cw_of(a), cr8, sel, inv, mode};
   endfunction

   // Push the expectation for the current cycle, then advance to just after the next edge.
   task automatic step(input int ua, input logic [CW-1:0] ctrl, input logic ovf,
                       input logic unf, input logic trip);
      logic [AW-1:0] ua8;
      ua8 = AW'(ua);
      cond_in[3:2] = 2'($urandom_range(0, 3));
      exp_q.push_back({ua8, ctrl, ovf, unf, trip});
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compares every cycle that has an expectation queued.
   always @(negedge CLK) begin
      logic [EW-1:0] e;
      logic [EW-1:0] g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {uaddr, ctrl_out, stk_ovf, stk_unf, wdt_trip};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL cycle%0d: got uaddr=%0h ctrl=%0h ovf=%b unf=%b trip=%b, want uaddr=%0h ctrl=%0h ovf=%b unf=%b trip=%b",
                     cyc, g[EW-1:CW+3], g[CW+2:3], g[2], g[1], g[0],
                     e[EW-1:CW+3], e[CW+2:3], e[2], e[1], e[0]);
         end
         cyc++;
      end
   end

   initial begin
      reset      = 1'b0;
      cond_in    = '0;
      entry_addr = '0;
      for (int a = 0; a < 256; a++) urom[a] = mk(M_INC, 1'b0, 2'd0, 0, a);
      urom[0]  = mk(M_INC,      1'b0, 2'd0, 0,  0);
      urom[1]  = mk(M_JUMP,     1'b0, 2'd0, 5,  1);
      urom[5]  = mk(M_DISPATCH, 1'b0, 2'd0, 0,  5);
      urom[38] = mk(M_JUMP,     1'b0, 2'd0, 10, 38);
      urom[10] = mk(M_CWAIT,    1'b0, 2'd0, 0,  10);
      urom[11] = mk(M_JUMP,     1'b0, 2'd0, 20, 11);
      urom[20] = mk(M_CJUMP,    1'b1, 2'd1, 40, 20);
      urom[21] = mk(M_JUMP,     1'b0, 2'd0, 20, 21);
      urom[40] = mk(M_CALL,     1'b0, 2'd0, 50, 40);
      urom[50] = mk(M_CALL,     1'b0, 2'd0, 60, 50);
      urom[60] = mk(M_CALL,     1'b0, 2'd0, 70, 60);
      urom[70] = mk(M_CALL,     1'b0, 2'd0, 80, 70);
      urom[80] = mk(M_CALL,     1'b0, 2'd0, 90, 80);
      urom[90] = mk(M_RET,      1'b0, 2'd0, 0,  90);
      urom[71] = mk(M_RET,      1'b0, 2'd0, 0,  71);
      urom[61] = mk(M_RET,      1'b0, 2'd0, 0,  61);
      urom[51] = mk(M_RET,      1'b0, 2'd0, 0,  51);
      urom[41] = mk(M_RET,      1'b0, 2'd0, 0,  41);
      urom[30] = mk(M_CWAIT,    1'b0, 2'd0, 0,  30);
      @(posedge CLK);
      #1;

      // Reset and release: 0 in reset, then 1, then 5.
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      reset = 1'b1;
      step(0, '0, 0, 0, 0);
      step(1, cw_of(0), 0, 0, 0);
      urom[0] = mk(M_RET, 1'b0, 2'd0, 0, 0);
      step(5, cw_of(1), 0, 0, 0);

      // Dispatch to 38.
      entry_addr = 8'd38;
      step(38, cw_of(5), 0, 0, 0);
      entry_addr = AW'($urandom_range(0, 255));

      // CWAIT at 10 holding MOC low for 3 cycles.
      cond_in[1:0] = 2'b00;
      step(10, cw_of(38), 0, 0, 0);
      step(10, cw_of(10), 0, 0, 0);
      step(10, cw_of(10), 0, 0, 0);
      step(10, cw_of(10), 0, 0, 0);
      cond_in[0] = 1'b1;
      step(11, cw_of(10), 0, 0, 0);
      cond_in[0] = 1'b0;
      step(20, cw_of(11), 0, 0, 0);

      // CJUMP at 20 on inverted Cond.
      cond_in[1] = 1'b1;
      step(21, cw_of(20), 0, 0, 0);
      step(20, cw_of(21), 0, 0, 0);
      cond_in[1] = 1'b0;
      step(40, cw_of(20), 0, 0, 0);

      // Five nested calls into a depth-4 stack, then six returns.
      step(50, cw_of(40), 0, 0, 0);
      step(60, cw_of(50), 0, 0, 0);
      step(70, cw_of(60), 0, 0, 0);
      step(80, cw_of(70), 0, 0, 0);
      step(90, cw_of(80), 0, 0, 0);
      step(71, cw_of(90), 1, 0, 0);
      step(61, cw_of(71), 1, 0, 0);
      step(51, cw_of(61), 1, 0, 0);
      step(41, cw_of(51), 1, 0, 0);
      step(0,  cw_of(41), 1, 0, 0);
      step(0,  cw_of(0),  1, 1, 0);
      step(0,  cw_of(0),  1, 1, 0);

      // Async reset clears the sticky flags; then reset in the middle of a CWAIT.
      reset = 1'b0;
      step(0, '0, 0, 0, 0);
      urom[0] = mk(M_JUMP, 1'b0, 2'd0, 10, 0);
      step(0, '0, 0, 0, 0);
      reset = 1'b1;
      step(0, '0, 0, 0, 0);
      step(10, cw_of(0), 0, 0, 0);
      step(10, cw_of(10), 0, 0, 0);
      step(10, cw_of(10), 0, 0, 0);
      reset = 1'b0;
      step(0, '0, 0, 0, 0);
      urom[0] = mk(M_JUMP, 1'b0, 2'd0, 30, 0);
      step(0, '0, 0, 0, 0);

      // CWAIT at 30 with MOC stuck low.
      reset = 1'b1;
      step(0, '0, 0, 0, 0);
      step(30, cw_of(0), 0, 0, 0);
      for (int i = 0; i < 4; i++) step(30, cw_of(30), 0, 0, 0);
`ifdef USEQ_WDT_EN
      step(8'hFF, cw_of(30), 0, 0, 0);
      step(0, cw_of(255), 0, 0, 1);
      step(30, cw_of(0), 0, 0, 1);
`else
      step(30, cw_of(30), 0, 0, 0);
      step(30, cw_of(30), 0, 0, 0);
      step(30, cw_of(30), 0, 0, 0);
`endif

      @(negedge CLK);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
